// File: rtl/spi_msg_tx_pkg.sv
// Shared widths and FSM encoding for the SPI message transmitter.
package spi_msg_tx_pkg;
  localparam int WORD_W = 16;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;
endpackage

// File: rtl/spi_msg_tx_fifo.sv
// Synchronous FIFO with show-ahead read data and registered full/empty flags
// that reflect the occupancy after the current cycle's push and pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_q
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt, w_cnt_nxt;
  logic             r_full, r_empty;
  logic             w_push, w_pop;

  assign w_push = i_wr && !r_full;
  assign w_pop  = i_rd && !r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)
      w_cnt_nxt = r_cnt + (AW+1)'(1);
    else if (!w_push && w_pop)
      w_cnt_nxt = r_cnt - (AW+1)'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_q     = r_mem[r_rp];
endmodule

// File: rtl/spi_msg_tx.sv
// Message-level SPI transmitter: queues committed messages and serializes
// them MSB-first, pausing between words while the far end raises RX_STOP.
module spi_msg_tx
  import spi_msg_tx_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int DEPTH    = 256,
  parameter int LQ_DEPTH = 4
) (
  input  logic              SYS_CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] WR_DATA,
  input  logic              WR_ENA,
  output logic              WR_FULL,
  input  logic              COMMIT,
  output logic              LQ_FULL,
  output logic              TX_CLK,
  output logic              TX_DATA,
  output logic              TX_LOAD,
  input  logic              RX_STOP,
  output logic              BUSY
);
  localparam int            DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  state_t            r_state, w_state_nxt;
  logic [DW-1:0]     r_div, w_div_nxt;
  logic              w_tick;
  logic              r_tx_clk, r_tx_data, r_tx_load;
  logic              r_stop_m, r_stop_s;
  logic [LEN_W-1:0]  r_wcnt, r_remain;
  logic [3:0]        r_bit;
  logic [WORD_W-1:0] r_sh;
  logic              w_wr_acc, w_commit_ok;
  logic              w_word_full, w_word_empty, w_word_pop;
  logic [WORD_W-1:0] w_word_q;
  logic              w_lq_full, w_lq_empty, w_lq_pop;
  logic [LEN_W-1:0]  w_lq_q;

  // w_tick marks the last cycle of a bit period; outputs update on it so they
  // change at count 0, coincident with the TX_CLK falling edge.
  assign w_tick    = (r_div == DIV_LAST);
  assign w_div_nxt = w_tick ? '0 : r_div + DW'(1);

  assign w_wr_acc    = WR_ENA && !w_word_full;
  assign w_commit_ok = COMMIT && (r_wcnt != '0) && !w_lq_full;

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_word_fifo (
    .i_clk   (SYS_CLK),
    .i_rst_n (RST),
    .i_wr    (WR_ENA),
    .i_wdata (WR_DATA),
    .i_rd    (w_word_pop),
    .o_full  (w_word_full),
    .o_empty (w_word_empty),
    .o_q     (w_word_q)
  );

  sync_fifo #(.WIDTH(LEN_W), .DEPTH(LQ_DEPTH)) u_len_q (
    .i_clk   (SYS_CLK),
    .i_rst_n (RST),
    .i_wr    (w_commit_ok),
    .i_wdata (r_wcnt),
    .i_rd    (w_lq_pop),
    .o_full  (w_lq_full),
    .o_empty (w_lq_empty),
    .o_q     (w_lq_q)
  );

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_div    <= '0;
      r_tx_clk <= 1'b0;
      r_stop_m <= 1'b0;
      r_stop_s <= 1'b0;
      r_wcnt   <= '0;
    end else begin
      r_div    <= w_div_nxt;
      r_tx_clk <= (w_div_nxt >= DIV_HALF);
      r_stop_m <= RX_STOP;
      r_stop_s <= r_stop_m;
      // A write in the committing cycle starts the next message.
      if (w_commit_ok)
        r_wcnt <= w_wr_acc ? LEN_W'(1) : '0;
      else if (w_wr_acc && (r_wcnt != '1))
        r_wcnt <= r_wcnt + LEN_W'(1);
    end
  end

  // GAP's closing boundary loads the next word directly so a word costs 17 periods.
  always_comb begin
    w_state_nxt = r_state;
    w_lq_pop    = 1'b0;
    w_word_pop  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_lq_empty) begin
          w_lq_pop    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_tick && !r_stop_s && !w_word_empty) begin
          w_word_pop  = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_tick && (r_bit == 4'd0))
          w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (w_tick) begin
          if (r_remain == '0)
            w_state_nxt = ST_IDLE;
          else if (r_stop_s || w_word_empty)
            w_state_nxt = ST_WAIT;
          else begin
            w_word_pop  = 1'b1;
            w_state_nxt = ST_SHIFT;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_remain  <= '0;
      r_bit     <= 4'd0;
      r_tx_data <= 1'b0;
      r_tx_load <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_lq_pop)
        r_remain <= w_lq_q;
      if (w_word_pop) begin
        r_tx_data <= w_word_q[WORD_W-1];
        r_tx_load <= 1'b1;
        r_bit     <= 4'd15;
      end else if ((r_state == ST_SHIFT) && w_tick) begin
        if (r_bit == 4'd0) begin
          r_tx_data <= 1'b0;
          r_tx_load <= 1'b0;
          r_remain  <= r_remain - LEN_W'(1);
        end else begin
          r_tx_data <= r_sh[WORD_W-2];
          r_bit     <= r_bit - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (w_word_pop)
      r_sh <= w_word_q;
    else if ((r_state == ST_SHIFT) && w_tick)
      r_sh <= r_sh << 1;
  end

  assign WR_FULL = w_word_full;
  assign LQ_FULL = w_lq_full;
  assign TX_CLK  = r_tx_clk;
  assign TX_DATA = r_tx_data;
  assign TX_LOAD = r_tx_load;
  assign BUSY    = !w_lq_empty || (r_state != ST_IDLE);
endmodule

// File: tb/tb_spi_msg_tx.sv
// Directed bench for spi_msg_tx: a serial monitor rebuilds words on TX_CLK
// rising edges and records TX_LOAD/BUSY edge times for timing checks.
module tb_spi_msg_tx;
  localparam int CLK_DIV = 4;
  localparam int P       = CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ena = 1'b0;
  logic        commit = 1'b0;
  logic        rx_stop = 1'b0;
  logic        wr_full, lq_full, tx_clk, tx_data, tx_load, busy;

  int checks = 0;
  int failures = 0;

  spi_msg_tx #(.CLK_DIV(CLK_DIV), .DEPTH(256), .LQ_DEPTH(4)) dut (
    .SYS_CLK (clk),
    .RST     (rst_n),
    .WR_DATA (wr_data),
    .WR_ENA  (wr_ena),
    .WR_FULL (wr_full),
    .COMMIT  (commit),
    .LQ_FULL (lq_full),
    .TX_CLK  (tx_clk),
    .TX_DATA (tx_data),
    .TX_LOAD (tx_load),
    .RX_STOP (rx_stop),
    .BUSY    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] rx_sh = '0;
  int          rx_bits = 0;
  logic [15:0] rxq[$];
  always @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_bits <= 0;
    end else if (tx_load) begin
      rx_sh <= {rx_sh[14:0], tx_data};
      if (rx_bits == 15) begin
        rxq.push_back({rx_sh[14:0], tx_data});
        rx_bits <= 0;
      end else begin
        rx_bits <= rx_bits + 1;
      end
    end
  end

  logic prev_load = 1'b0;
  logic prev_busy = 1'b0;
  int   rise_t[$];
  int   fall_t[$];
  int   bfall_t[$];
  int   busy_cnt = 0;
  always @(negedge clk) begin
    if (tx_load && !prev_load) rise_t.push_back(cyc);
    if (!tx_load && prev_load) fall_t.push_back(cyc);
    if (!busy && prev_busy)    bfall_t.push_back(cyc);
    if (busy) busy_cnt <= busy_cnt + 1;
    prev_load <= tx_load;
    prev_busy <= busy;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_word(input logic [15:0] d);
    wr_data = d; wr_ena = 1'b1;
    step();
    wr_ena = 1'b0;
  endtask

  task automatic do_commit(output int n);
    n = cyc; commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    step();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_clk, tx_data, tx_load, busy, wr_full, lq_full} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {tx_clk, tx_data, tx_load, busy, wr_full, lq_full});
    end
    step(); rst_n = 1'b1; step();
    checks++;
    if (rise_t.size() != 0) begin
      failures++;
      $display("FAIL reset_no_load: got %0d rises expected 0", rise_t.size());
    end
  endtask

  task automatic test_single();
    int r0, f0, b0, q0, n;
    bit ok;
    r0 = rise_t.size(); f0 = fall_t.size(); b0 = bfall_t.size(); q0 = rxq.size();
    write_word(16'hA5C3);
    write_word(16'h0001);
    do_commit(n);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL single_busy_n1: got %b expected 1", busy);
    end
    step();
    wait_idle(1000, ok);
    checks++;
    if (!ok || rise_t.size() - r0 != 2 || fall_t.size() - f0 != 2 || bfall_t.size() - b0 != 1) begin
      failures++;
      $display("FAIL single_edges: ok=%0d rises=%0d falls=%0d busyfalls=%0d expected 1/2/2/1",
               ok, rise_t.size() - r0, fall_t.size() - f0, bfall_t.size() - b0);
    end else begin
      checks++;
      if (rise_t[r0] - n < 3 || rise_t[r0] - n > 3 + P - 1) begin
        failures++;
        $display("FAIL single_first_rise: got N+%0d expected N+3..N+%0d", rise_t[r0] - n, 3 + P - 1);
      end
      checks++;
      if (fall_t[f0] - rise_t[r0] != 16 * P) begin
        failures++;
        $display("FAIL single_window: got %0d cycles expected %0d", fall_t[f0] - rise_t[r0], 16 * P);
      end
      checks++;
      if (rise_t[r0+1] - rise_t[r0] != 17 * P) begin
        failures++;
        $display("FAIL single_word_pitch: got %0d expected %0d", rise_t[r0+1] - rise_t[r0], 17 * P);
      end
      checks++;
      if (bfall_t[b0] - fall_t[f0+1] != P) begin
        failures++;
        $display("FAIL single_busy_fall: got %0d expected %0d", bfall_t[b0] - fall_t[f0+1], P);
      end
    end
    checks++;
    if (rxq.size() - q0 != 2 || rxq[q0] !== 16'hA5C3 || rxq[q0+1] !== 16'h0001) begin
      failures++;
      $display("FAIL single_data: got %0d words first %h expected A5C3 0001",
               rxq.size() - q0, (rxq.size() > q0) ? rxq[q0] : 16'hxxxx);
    end
  endtask

  task automatic test_backpressure();
    int r0, q0, n;
    bit ok;
    rx_stop = 1'b1;
    repeat (3) step();
    r0 = rise_t.size(); q0 = rxq.size();
    write_word(16'h1111); write_word(16'h2222); write_word(16'h3333);
    do_commit(n);
    repeat (200) step();
    checks++;
    if (rise_t.size() - r0 != 0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_held: rises=%0d busy=%b expected 0/1", rise_t.size() - r0, busy);
    end
    rx_stop = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (rise_t.size() - r0 == 2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++; $display("FAIL bp_word2_start: got %0d rises expected 2", rise_t.size() - r0);
    end
    repeat (8) step();
    rx_stop = 1'b1;
    repeat (300) step();
    checks++;
    if (rxq.size() - q0 != 2 || rise_t.size() - r0 != 2) begin
      failures++;
      $display("FAIL bp_word3_held: got %0d words %0d rises expected 2/2",
               rxq.size() - q0, rise_t.size() - r0);
    end
    rx_stop = 1'b0;
    wait_idle(1000, ok);
    checks++;
    if (!ok || rxq.size() - q0 != 3 || rxq[q0] !== 16'h1111 || rxq[q0+1] !== 16'h2222 ||
        rxq[q0+2] !== 16'h3333) begin
      failures++;
      $display("FAIL bp_data: ok=%0d got %0d words expected 3 (1111 2222 3333)", ok, rxq.size() - q0);
    end
  endtask

  task automatic test_zero_len();
    int r0, b0, n;
    r0 = rise_t.size(); b0 = busy_cnt;
    do_commit(n);
    repeat (50) step();
    checks++;
    if (busy_cnt - b0 != 0 || rise_t.size() - r0 != 0) begin
      failures++;
      $display("FAIL zero_len: busy cycles=%0d rises=%0d expected 0/0", busy_cnt - b0, rise_t.size() - r0);
    end
  endtask

  task automatic test_full();
    int q0, n, errs;
    bit ok;
    rx_stop = 1'b1;
    repeat (3) step();
    q0 = rxq.size();
    for (int i = 0; i < 200; i++) write_word(16'(i));
    do_commit(n);
    for (int i = 200; i < 256; i++) write_word(16'(i));
    checks++;
    if (wr_full !== 1'b1) begin
      failures++; $display("FAIL full_flag: got %b expected 1", wr_full);
    end
    write_word(16'hDEAD);
    checks++;
    if (wr_full !== 1'b1) begin
      failures++; $display("FAIL full_after_drop: got %b expected 1", wr_full);
    end
    do_commit(n);
    rx_stop = 1'b0;
    wait_idle(20000, ok);
    checks++;
    if (!ok || rxq.size() - q0 != 256) begin
      failures++;
      $display("FAIL full_count: ok=%0d got %0d words expected 256", ok, rxq.size() - q0);
    end
    errs = 0;
    for (int i = 0; i < 256 && q0 + i < rxq.size(); i++)
      if (rxq[q0+i] !== 16'(i)) errs++;
    checks++;
    if (errs != 0) begin
      failures++; $display("FAIL full_data: got %0d wrong words expected 0", errs);
    end
    checks++;
    if (wr_full !== 1'b0) begin
      failures++; $display("FAIL full_cleared: got %b expected 0", wr_full);
    end
  endtask

  task automatic test_lq_full();
    int q0, n, errs;
    bit ok;
    rx_stop = 1'b1;
    repeat (3) step();
    q0 = rxq.size();
    // The first length is popped into the FSM at once, so four more fill the queue.
    for (int k = 0; k < 6; k++) begin
      write_word(16'h5000 + 16'(k));
      do_commit(n);
      if (k == 3) begin
        checks++;
        if (lq_full !== 1'b0) begin
          failures++; $display("FAIL lq_not_full_yet: got %b expected 0", lq_full);
        end
      end
      if (k == 4 || k == 5) begin
        checks++;
        if (lq_full !== 1'b1) begin
          failures++; $display("FAIL lq_full_k%0d: got %b expected 1", k, lq_full);
        end
      end
    end
    rx_stop = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (!lq_full) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++; $display("FAIL lq_drain: got lq_full=%b expected 0", lq_full);
    end
    do_commit(n);
    repeat (4) step();
    wait_idle(3000, ok);
    errs = 0;
    for (int k = 0; k < 6 && q0 + k < rxq.size(); k++)
      if (rxq[q0+k] !== 16'h5000 + 16'(k)) errs++;
    checks++;
    if (!ok || rxq.size() - q0 != 6 || errs != 0) begin
      failures++;
      $display("FAIL lq_data: ok=%0d got %0d words %0d wrong expected 6/0", ok, rxq.size() - q0, errs);
    end
  endtask

  task automatic test_commit_write();
    int r0, q0, n;
    bit ok;
    r0 = rise_t.size(); q0 = rxq.size();
    write_word(16'hC001);
    wr_data = 16'hC002; wr_ena = 1'b1; commit = 1'b1;
    step();
    wr_ena = 1'b0;
    step();
    commit = 1'b0;
    repeat (4) step();
    wait_idle(1000, ok);
    checks++;
    if (!ok || rxq.size() - q0 != 2 || rxq[q0] !== 16'hC001 || rxq[q0+1] !== 16'hC002) begin
      failures++;
      $display("FAIL cw_data: ok=%0d got %0d words expected C001 C002", ok, rxq.size() - q0);
    end
    checks++;
    if (rise_t.size() - r0 != 2) begin
      failures++; $display("FAIL cw_rises: got %0d expected 2", rise_t.size() - r0);
    end else begin
      checks++;
      if (rise_t[r0+1] - rise_t[r0] != 18 * P) begin
        failures++;
        $display("FAIL cw_two_msgs: got pitch %0d expected %0d", rise_t[r0+1] - rise_t[r0], 18 * P);
      end
    end
  endtask

  task automatic test_reset_mid();
    int r0, q0, n;
    bit ok;
    r0 = rise_t.size();
    write_word(16'h00FF); write_word(16'hFFFF);
    do_commit(n);
    write_word(16'hAAAA);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rise_t.size() > r0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rst_word_start: got %0d rises expected 1", rise_t.size() - r0);
    end
    repeat (8 * P + 1) @(negedge clk);
    checks++;
    if (tx_load !== 1'b1 || tx_data !== 1'b1) begin
      failures++; $display("FAIL rst_bit7_pre: load=%b data=%b expected 1/1", tx_load, tx_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_load !== 1'b0 || tx_data !== 1'b0 || tx_clk !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_drop: load=%b data=%b clk=%b expected 0/0/0", tx_load, tx_data, tx_clk);
    end
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || wr_full !== 1'b0 || lq_full !== 1'b0) begin
      failures++; $display("FAIL rst_post_state: busy=%b wr_full=%b lq_full=%b expected 0/0/0",
                           busy, wr_full, lq_full);
    end
    q0 = rxq.size();
    write_word(16'h1234);
    do_commit(n);
    repeat (4) step();
    wait_idle(1000, ok);
    checks++;
    if (!ok || rxq.size() - q0 != 1 || rxq[q0] !== 16'h1234) begin
      failures++;
      $display("FAIL rst_no_residue: ok=%0d got %0d words first %h expected 1 word 1234",
               ok, rxq.size() - q0, (rxq.size() > q0) ? rxq[q0] : 16'hxxxx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_zero_len();
    test_full();
    test_lq_full();
    test_commit_write();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
